// File: rtl/l1pa_shift_offset_gen.sv
// L1PA shift-offset generator: accumulates per-page deltas modulo the share group size.
// Optional debug counters are enabled by defining SHIFT_OFFSET_DBG_CNT_EN.
module l1pa_shift_offset_gen #(
    parameter int SHARE_GROUP_SIZE   = 5,
    parameter int SHIFT_WIDTH        = 3,
    parameter int MAX_ALLOC_SEQ_NUM  = 2,
    parameter int SHIFT_OFFSET_DELAY = 3
) (
    input  logic                   sys_clk,
    input  logic                   rstn,
    input  logic                   flush_i,
    input  logic                   delta_valid_i,
    input  logic [SHIFT_WIDTH-1:0] delta_i,
    input  logic                   seq_start_i,
    input  logic                   seq_end_i,
    output logic                   offset_valid_o,
    output logic [SHIFT_WIDTH-1:0] shift_offset_o,
    output logic                   seq_last_o,
    output logic                   proto_err_o
`ifdef SHIFT_OFFSET_DBG_CNT_EN
    ,
    output logic [15:0]            dbg_seq_cnt_o,
    output logic                   dbg_err_sticky_o
`endif
);

    localparam int SW1   = SHIFT_WIDTH + 1;
    localparam int CNT_W = (MAX_ALLOC_SEQ_NUM > 2) ? $clog2(MAX_ALLOC_SEQ_NUM) : 1;
    localparam logic [SHIFT_WIDTH-1:0] GRP      = SHIFT_WIDTH'(SHARE_GROUP_SIZE);
    localparam logic [SHIFT_WIDTH:0]   GRP_W    = SW1'(SHARE_GROUP_SIZE);
    localparam logic [CNT_W-1:0]       CNT_LAST = CNT_W'(MAX_ALLOC_SEQ_NUM - 1);

    if (SHIFT_OFFSET_DELAY != 3) begin : g_delay_chk
        $error("l1pa_shift_offset_gen: only SHIFT_OFFSET_DELAY=3 is supported");
    end

    typedef enum logic {IDLE, IN_SEQ} state_t;

    logic                   s1_valid;
    logic [SHIFT_WIDTH-1:0] s1_delta;
    logic                   s1_start;
    logic                   s1_end;

    logic                   s2_valid;
    logic [SHIFT_WIDTH-1:0] s2_off;
    logic                   s2_last;
    logic                   s2_err;

    state_t                 state;
    state_t                 state_n;
    logic [CNT_W-1:0]       cnt;
    logic [CNT_W-1:0]       cnt_n;
    logic [SHIFT_WIDTH-1:0] acc;
    logic [SHIFT_WIDTH-1:0] acc_n;
    logic                   last_n;
    logic                   err_n;
    logic                   restart;
    logic [SHIFT_WIDTH-1:0] red_delta;
    logic [SHIFT_WIDTH:0]   sum;
    logic [SHIFT_WIDTH:0]   sum_mod;

    assign red_delta = (delta_i >= GRP) ? delta_i - GRP : delta_i;

    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            s1_valid <= 1'b0;
            s1_delta <= '0;
            s1_start <= 1'b0;
            s1_end   <= 1'b0;
        end else if (flush_i) begin
            s1_valid <= 1'b0;
        end else begin
            s1_valid <= delta_valid_i;
            if (delta_valid_i) begin
                s1_delta <= red_delta;
                s1_start <= seq_start_i;
                s1_end   <= seq_end_i;
            end
        end
    end

    assign sum     = {1'b0, acc} + {1'b0, s1_delta};
    assign sum_mod = (sum >= GRP_W) ? sum - GRP_W : sum;

    // An element arriving while IDLE always opens a new sequence.
    always_comb begin
        restart = s1_start || (state == IDLE);
        err_n   = (state == IDLE) ? !s1_start : s1_start;
        acc_n   = restart ? s1_delta : sum_mod[SHIFT_WIDTH-1:0];
        state_n = state;
        cnt_n   = cnt;
        last_n  = 1'b0;
        unique case (1'b1)
            restart: begin
                cnt_n   = CNT_W'(1);
                last_n  = s1_end;
                state_n = s1_end ? IDLE : IN_SEQ;
            end
            (!restart && s1_end): begin
                last_n  = 1'b1;
                state_n = IDLE;
            end
            (!restart && !s1_end && (cnt == CNT_LAST)): begin
                err_n   = 1'b1;
                last_n  = 1'b1;
                state_n = IDLE;
            end
            default: begin
                cnt_n = cnt + CNT_W'(1);
            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            cnt      <= '0;
            acc      <= '0;
            s2_valid <= 1'b0;
            s2_off   <= '0;
            s2_last  <= 1'b0;
            s2_err   <= 1'b0;
        end else if (flush_i) begin
            s2_valid <= 1'b0;
            state    <= IDLE;
        end else begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                acc     <= acc_n;
                state   <= state_n;
                cnt     <= cnt_n;
                s2_off  <= acc_n;
                s2_last <= last_n;
                s2_err  <= err_n;
            end
        end
    end

    // Outputs are forced to zero whenever no offset is valid.
    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            offset_valid_o <= 1'b0;
            shift_offset_o <= '0;
            seq_last_o     <= 1'b0;
            proto_err_o    <= 1'b0;
        end else if (flush_i) begin
            offset_valid_o <= 1'b0;
            shift_offset_o <= '0;
            seq_last_o     <= 1'b0;
            proto_err_o    <= 1'b0;
        end else begin
            offset_valid_o <= s2_valid;
            shift_offset_o <= s2_valid ? s2_off : '0;
            seq_last_o     <= s2_valid && s2_last;
            proto_err_o    <= s2_valid && s2_err;
        end
    end

`ifdef SHIFT_OFFSET_DBG_CNT_EN
    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            dbg_seq_cnt_o    <= '0;
            dbg_err_sticky_o <= 1'b0;
        end else begin
            if (offset_valid_o && seq_last_o && (dbg_seq_cnt_o != 16'hFFFF))
                dbg_seq_cnt_o <= dbg_seq_cnt_o + 16'd1;
            if (proto_err_o || (delta_valid_i && (delta_i >= GRP)))
                dbg_err_sticky_o <= 1'b1;
        end
    end
`endif

endmodule
